// File: rtl/serial_subtractor_32_pkg.sv
// Shared definitions for the digit-serial subtractor: FSM state encoding
// and the WIDTH/DIGIT legality rule.
package serial_subtractor_32_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic bit params_legal(input int unsigned width, input int unsigned digit);
        bit digit_ok;
        digit_ok = (digit == 1) || (digit == 2) || (digit == 4) ||
                   (digit == 8) || (digit == 16) || (digit == 32);
        return digit_ok && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/serial_subtractor_32_fs.sv
// Single-bit full subtractor: d = a - b - bin, bout set when the bit underflows.
module one_bit_full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor_32.sv
// Digit-serial subtractor d = x - y, DIGIT bits per clock LSB first,
// behind a start/done handshake with one operation in flight.
module serial_subtractor_32
    import serial_subtractor_32_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             b31,
    output logic             ovf
);

    localparam int unsigned NSTEP = WIDTH / DIGIT;
    localparam int unsigned CW    = $clog2(NSTEP + 1);

    if (!params_legal(WIDTH, DIGIT)) begin : g_bad_params
        $error("serial_subtractor_32: illegal WIDTH/DIGIT combination");
    end

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             borrow_q;
    logic [CW-1:0]    cnt_q;
    logic             xs_q;
    logic             ys_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] d_q;
    logic             b31_q;
    logic             ovf_q;

    logic [DIGIT:0]         bchain;
    logic [DIGIT-1:0]       dig;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0]       res_d;
    logic                   last_d;
    logic                   ovf_d;

    assign bchain[0] = borrow_q;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fs
        one_bit_full_subtractor u_fs (
            .a    (a_q[i]),
            .b    (b_q[i]),
            .bin  (bchain[i]),
            .d    (dig[i]),
            .bout (bchain[i+1])
        );
    end

    // New digit enters at the MSB side; after NSTEP steps the LSB digit has reached bit 0.
    always_comb begin
        res_cat = {dig, res_q};
        res_d   = res_cat[WIDTH+DIGIT-1:DIGIT];
        last_d  = (cnt_q == CW'(NSTEP - 1));
        ovf_d   = (xs_q != ys_q) && (res_d[WIDTH-1] != xs_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            xs_q     <= 1'b0;
            ys_q     <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            d_q      <= '0;
            b31_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q      <= x;
                        b_q      <= y;
                        xs_q     <= x[WIDTH-1];
                        ys_q     <= y[WIDTH-1];
                        res_q    <= '0;
                        borrow_q <= 1'b0;
                        cnt_q    <= '0;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_q      <= a_q >> DIGIT;
                    b_q      <= b_q >> DIGIT;
                    res_q    <= res_d;
                    borrow_q <= bchain[DIGIT];
                    cnt_q    <= cnt_q + CW'(1);
                    if (last_d) begin
                        d_q     <= res_d;
                        b31_q   <= bchain[DIGIT];
                        ovf_q   <= ovf_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign d     = d_q;
    assign b31   = b31_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor_32.sv
// Self-checking bench for serial_subtractor_32: directed vectors, random
// operands against an arithmetic model, handshake corner cases, DIGIT=4 streaming.
module tb_serial_subtractor_32;

    logic        clk = 1'b0;
    logic        rst, start, start4;
    logic [31:0] x, y, x4, y4;
    logic        ready, busy, done, b31, ovf;
    logic        ready4, busy4, done4, b314, ovf4;
    logic [31:0] d, d4;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    serial_subtractor_32 #(.WIDTH(32), .DIGIT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
        .ready(ready), .busy(busy), .done(done), .d(d), .b31(b31), .ovf(ovf)
    );

    serial_subtractor_32 #(.WIDTH(32), .DIGIT(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .x(x4), .y(y4),
        .ready(ready4), .busy(busy4), .done(done4), .d(d4), .b31(b314), .ovf(ovf4)
    );

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; start4 = 1'b1;
        x = 32'h1234_5678; y = 32'h0000_0001; x4 = '0; y4 = '0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({ready, busy, done, d, b31, ovf} !== {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            failed++;
            $display("FAIL reset_state: ready=%b busy=%b done=%b d=%h b31=%b ovf=%b, required 1 0 0 00000000 0 0",
                     ready, busy, done, d, b31, ovf);
        end
        tests++;
        if ({ready4, busy4, done4} !== 3'b100) begin
            failed++;
            $display("FAIL reset_state_d4: ready/busy/done=%b%b%b, required 100", ready4, busy4, done4);
        end
        start = 1'b0; start4 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b0) begin
            failed++;
            $display("FAIL rst_beats_start: busy=%b, required 0", busy);
        end
    endtask

    // One full operation on the DIGIT=1 instance; optionally pulses start mid-run with new operands.
    task automatic do_op(input logic [31:0] xv, input logic [31:0] yv, input bit poke);
        logic [31:0] exp_d;
        logic        exp_b, exp_o;
        int          n;
        bit          seen;
        exp_d = xv - yv;
        exp_b = (xv < yv);
        exp_o = (xv[31] != yv[31]) && (exp_d[31] != xv[31]);
        @(negedge clk);
        x = xv; y = yv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        x = $urandom; y = $urandom;
        tests++;
        if ({ready, busy, done} !== 3'b010) begin
            failed++;
            $display("FAIL accept_flags x=%h y=%h: ready/busy/done=%b%b%b, required 010",
                     xv, yv, ready, busy, done);
        end
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (done) seen = 1'b1;
            if (poke && n == 5) start = 1'b1;
            if (poke && n == 6) start = 1'b0;
        end
        tests++;
        if (!seen || n != 32) begin
            failed++;
            $display("FAIL latency x=%h y=%h: done seen=%b after %0d cycles, required 32", xv, yv, seen, n);
        end
        tests++;
        if ({d, b31, ovf} !== {exp_d, exp_b, exp_o}) begin
            failed++;
            $display("FAIL result x=%h y=%h: d=%h b31=%b ovf=%b, required d=%h b31=%b ovf=%b",
                     xv, yv, d, b31, ovf, exp_d, exp_b, exp_o);
        end
        tests++;
        if ({ready, busy} !== 2'b10) begin
            failed++;
            $display("FAIL done_flags: ready/busy=%b%b, required 10", ready, busy);
        end
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b0 || d !== exp_d) begin
            failed++;
            $display("FAIL done_pulse_hold: done=%b d=%h, required done=0 d=%h", done, d, exp_d);
        end
    endtask

    task automatic test_directed();
        do_op(32'h0000_000D, 32'h0000_000D, 1'b0);
        do_op(32'h0000_0002, 32'h0000_000D, 1'b0);
        do_op(32'h1000_000D, 32'h0800_010D, 1'b0);
        do_op(32'h0000_010D, 32'h0000_000D, 1'b0);
        do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    endtask

    task automatic test_start_in_run();
        do_op(32'h8000_0000, 32'h0000_0001, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) do_op($urandom, $urandom, (i % 3) == 0);
    endtask

    task automatic test_reset_mid_run();
        int pulses;
        @(negedge clk);
        x = 32'hDEAD_BEEF; y = 32'h0123_4567; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        pulses = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++;
        if ({ready, busy, done, d, b31, ovf} !== {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            failed++;
            $display("FAIL reset_mid_run: ready=%b busy=%b done=%b d=%h b31=%b ovf=%b, required 1 0 0 00000000 0 0",
                     ready, busy, done, d, b31, ovf);
        end
        repeat (40) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        tests++;
        if (pulses != 0) begin
            failed++;
            $display("FAIL abort_no_done: %0d done pulses, required 0", pulses);
        end
        do_op(32'hDEAD_BEEF, 32'h0123_4567, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] xs [5];
        logic [31:0] ys [5];
        logic [31:0] exp_d;
        int          n;
        for (int i = 0; i < 5; i++) begin
            xs[i] = $urandom; ys[i] = $urandom;
        end
        xs[0] = 32'h8000_0000; ys[0] = 32'h0000_0001;
        @(negedge clk);
        x4 = xs[0]; y4 = ys[0]; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            while (!done4 && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            tests++;
            if (n != 8) begin
                failed++;
                $display("FAIL b2b_latency op%0d: done after %0d cycles, required 8", i, n);
            end
            exp_d = xs[i] - ys[i];
            tests++;
            if ({d4, b314, ovf4} !== {exp_d, xs[i] < ys[i],
                                      (xs[i][31] != ys[i][31]) && (exp_d[31] != xs[i][31])}) begin
                failed++;
                $display("FAIL b2b_result op%0d x=%h y=%h: d=%h b31=%b ovf=%b, required d=%h",
                         i, xs[i], ys[i], d4, b314, ovf4, exp_d);
            end
            if (i < 4) begin
                x4 = xs[i+1]; y4 = ys[i+1]; start4 = 1'b1;
                @(posedge clk); #1;
                start4 = 1'b0;
                tests++;
                if ({busy4, done4} !== 2'b10) begin
                    failed++;
                    $display("FAIL b2b_no_bubble op%0d: busy/done=%b%b, required 10", i + 1, busy4, done4);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_in_run();
        test_random();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
